ps2_scan_framer: RTL and testbench

- Sits between the PS/2 byte receiver and the PicoBlaze keyboard read path.
- Consumes raw bytes: rx_done_tick plus the 8-bit dout.
- Strips the E0 (extended) and F0 (break) prefixes and discards keyboard housekeeping bytes.
- Holds one complete key event in a register that the processor reads over port_id/read_strobe. Key-command decoding downstream sees only clean make/break events.

---
 rtl/ps2_scan_framer.sv | 150 +++++++++++++++
 tb/tb_ps2_scan_framer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scan_framer.sv
// PS/2 scan framer: strips E0/F0 prefixes, drops housekeeping bytes and
// holds one clean make/break event for the PicoBlaze read path.
//
// Ports:
//   clk, reset (async, active-low)
//   rx_done_tick, scan_in       : byte stream from the PS/2 receiver
//   read_strobe, port_id        : PicoBlaze read access
//   out_port                    : read data (combinational mux on port_id)
//   key_tick                    : one-cycle pulse when an event is loaded
//   key_valid, key_code,
//   key_ext, key_break          : held event
//   overflow                    : sticky, an event was dropped
module ps2_scan_framer #(
    parameter logic [7:0] PORT_CODE   = 8'h0F,
    parameter logic [7:0] PORT_STATUS = 8'h0E,
    parameter int         TIMEOUT_CYC = 2_500_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_done_tick,
    input  logic [7:0] scan_in,
    input  logic       read_strobe,
    input  logic [7:0] port_id,
    output logic [7:0] out_port,
    output logic       key_tick,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_break,
    output logic       overflow
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        GOT_E0,
        GOT_F0,
        GOT_E0F0
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;

    logic emit, ev_ext, ev_brk;
    logic is_e0, is_f0, is_pfx, is_hk;
    logic code_rd, stat_rd, load, drop;

    assign is_e0  = (scan_in == 8'hE0);
    assign is_f0  = (scan_in == 8'hF0);
    assign is_pfx = is_e0 | is_f0;
    assign is_hk  = scan_in inside {8'hAA, 8'hFA, 8'hEE,
                                    8'hFE, 8'h00, 8'hFF};

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        emit    = 1'b0;
        ev_ext  = 1'b0;
        ev_brk  = 1'b0;
        if (rx_done_tick) begin
            cnt_n = '0;
            unique case (state)
                IDLE: begin
                    if (is_e0)
                        state_n = GOT_E0;
                    else if (is_f0)
                        state_n = GOT_F0;
                    else if (!is_hk)
                        emit = 1'b1;
                end
                GOT_E0: begin
                    if (is_f0) begin
                        state_n = GOT_E0F0;
                    end else if (!is_e0) begin
                        state_n = IDLE;
                        emit    = 1'b1;
                        ev_ext  = 1'b1;
                    end
                end
                GOT_F0: begin
                    state_n = IDLE;
                    emit    = !is_pfx;
                    ev_brk  = 1'b1;
                end
                GOT_E0F0: begin
                    state_n = IDLE;
                    emit    = !is_pfx;
                    ev_ext  = 1'b1;
                    ev_brk  = 1'b1;
                end
            endcase
        end else if (state != IDLE) begin
            // abandon a stalled prefix sequence
            if (cnt == TO_LAST) begin
                state_n = IDLE;
                cnt_n   = '0;
            end else begin
                cnt_n = cnt + 1'b1;
            end
        end else begin
            cnt_n = '0;
        end
    end

    assign code_rd = read_strobe && (port_id == PORT_CODE);
    assign stat_rd = read_strobe && (port_id == PORT_STATUS);
    // a same-cycle code read frees the holding register for the new event
    assign load    = emit && (!key_valid || code_rd);
    assign drop    = emit && !load;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            key_tick  <= 1'b0;
            key_valid <= 1'b0;
            key_code  <= 8'h00;
            key_ext   <= 1'b0;
            key_break <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            key_tick <= load;
            if (load) begin
                key_valid <= 1'b1;
                key_code  <= scan_in;
                key_ext   <= ev_ext;
                key_break <= ev_brk;
            end else if (code_rd) begin
                key_valid <= 1'b0;
            end
            if (drop)
                overflow <= 1'b1;
            else if (stat_rd)
                overflow <= 1'b0;
        end
    end

    always_comb begin
        out_port = 8'h00;
        if (port_id == PORT_CODE)
            out_port = key_code;
        else if (port_id == PORT_STATUS)
            out_port = {overflow, 4'b0000, key_break, key_ext, key_valid};
    end

endmodule

// File: tb/tb_ps2_scan_framer.sv
// Testbench for ps2_scan_framer: directed + random byte streams checked
// against a prefix-list reference model through an event scoreboard.
module tb_ps2_scan_framer;

    localparam int TO = 16;
    localparam logic [7:0] PC = 8'h0F;
    localparam logic [7:0] PS = 8'h0E;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx_done_tick = 1'b0;
    logic [7:0] scan_in = 8'h00;
    logic       read_strobe = 1'b0;
    logic [7:0] port_id = 8'h00;
    logic [7:0] out_port;
    logic       key_tick, key_valid, key_ext, key_break, overflow;
    logic [7:0] key_code;

    ps2_scan_framer #(
        .PORT_CODE(PC), .PORT_STATUS(PS), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick),
        .scan_in(scan_in), .read_strobe(read_strobe), .port_id(port_id),
        .out_port(out_port), .key_tick(key_tick), .key_valid(key_valid),
        .key_code(key_code), .key_ext(key_ext), .key_break(key_break),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         due;
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } ev_t;

    ev_t        sb[$];
    logic [7:0] pfx[$];
    int         last_byte = 0;
    int         n_chk = 0;
    int         n_fail = 0;
    bit         mon_en = 0;

    logic       m_valid = 0, m_ext = 0, m_brk = 0, m_ovf = 0;
    logic [7:0] m_code = 8'h00;

    function automatic void chk(string name, logic [31:0] act,
                                logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endfunction

    function automatic bit is_hk(logic [7:0] b);
        return b == 8'hAA || b == 8'hFA || b == 8'hEE ||
               b == 8'hFE || b == 8'h00 || b == 8'hFF;
    endfunction

    function automatic void model_clear();
        m_valid = 0; m_ext = 0; m_brk = 0; m_ovf = 0; m_code = 8'h00;
        sb.delete();
        pfx.delete();
    endfunction

    // one clock: drive inputs, check the read mux, advance the model
    task automatic step(input logic rx, input logic [7:0] b,
                        input logic rs = 1'b0, input logic [7:0] pid = 8'h00);
        logic [7:0] exp_out;
        bit ev, e_ext, e_brk, crd, srd, ld;
        @(negedge clk);
        #1;
        rx_done_tick = rx;
        scan_in      = b;
        read_strobe  = rs;
        port_id      = pid;
        #1;
        if (pid == PC)
            exp_out = m_code;
        else if (pid == PS)
            exp_out = {m_ovf, 4'b0000, m_brk, m_ext, m_valid};
        else
            exp_out = 8'h00;
        chk("out_port", 32'(out_port), 32'(exp_out));
        ev = 0; e_ext = 0; e_brk = 0;
        if (rx) begin
            last_byte = cyc;
            if (b == 8'hE0 || b == 8'hF0) begin
                if (pfx.size() == 0)
                    pfx.push_back(b);
                else if (pfx.size() == 1 && pfx[0] == 8'hE0) begin
                    if (b == 8'hF0) pfx.push_back(b);
                end else
                    pfx.delete();
            end else if (pfx.size() == 0 && is_hk(b)) begin
                ev = 0;
            end else begin
                ev = 1;
                foreach (pfx[i]) begin
                    if (pfx[i] == 8'hE0) e_ext = 1;
                    if (pfx[i] == 8'hF0) e_brk = 1;
                end
                pfx.delete();
            end
        end else if (pfx.size() != 0 && cyc - last_byte >= TO) begin
            pfx.delete();
        end
        crd = rs && pid == PC;
        srd = rs && pid == PS;
        ld  = ev && (!m_valid || crd);
        if (ld) begin
            m_valid = 1; m_code = b; m_ext = e_ext; m_brk = e_brk;
            sb.push_back('{cyc + 1, b, e_ext, e_brk});
        end else if (crd) begin
            m_valid = 0;
        end
        if (ev && !ld)
            m_ovf = 1;
        else if (srd)
            m_ovf = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00);
    endtask

    task automatic chk_zero(string name);
        chk(name, 32'({key_tick, key_valid, key_code, key_ext,
                       key_break, overflow, out_port}), 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rx_done_tick = 0; read_strobe = 0; port_id = PS;
        reset = 0;
        #1;
        chk_zero("reset_flags");
        model_clear();
        @(negedge clk);
        #1;
        chk_zero("reset_hold");
        reset = 1;
    endtask

    // monitor: every key_tick must match the scoreboard head, on time
    always @(negedge clk) begin
        if (mon_en && reset) begin
            if (key_tick) begin
                if (sb.size() == 0) begin
                    chk("unexpected_tick", 32'd1, 32'd0);
                end else begin
                    ev_t e;
                    e = sb.pop_front();
                    chk("tick_time", 32'(cyc), 32'(e.due));
                    chk("tick_event", 32'({key_code, key_ext, key_break}),
                        32'({e.code, e.ext, e.brk}));
                end
            end else if (sb.size() != 0 && sb[0].due <= cyc) begin
                chk("missing_tick", 32'(cyc), 32'(sb[0].due));
                void'(sb.pop_front());
            end
            chk("held_state",
                32'({key_valid, key_code, key_ext, key_break, overflow}),
                32'({m_valid, m_code, m_ext, m_brk, m_ovf}));
        end
    end

    logic [7:0] pool[10] = '{8'hE0, 8'hF0, 8'hAA, 8'hFA, 8'h1C,
                             8'h32, 8'h75, 8'h74, 8'h23, 8'hE0};
    logic [7:0] ports[3] = '{8'h0F, 8'h0E, 8'h33};

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk_zero("reset_state");
        reset = 1;
        mon_en = 1;

        // plain make, status read, code read
        step(1, 8'h1C);
        step(0, 8'h00, 1, PS);
        step(0, 8'h00, 1, PC);
        idle(2);
        // extended break, extended make, housekeeping
        step(1, 8'hE0); step(1, 8'hF0); step(1, 8'h75);
        step(0, 8'h00, 0, PS);
        step(0, 8'h00, 1, PC);
        step(1, 8'hE0); step(1, 8'h75);
        step(0, 8'h00, 1, PC);
        step(1, 8'hAA); step(1, 8'hFA);
        idle(2);
        // overflow then status clear
        step(1, 8'h1C);
        step(1, 8'h32);
        step(0, 8'h00, 1, PS);
        step(0, 8'h00, 1, PS);
        step(0, 8'h00, 1, PC);
        // timeout abandons the break prefix
        step(1, 8'hF0);
        idle(TO);
        step(1, 8'h1C);
        step(0, 8'h00, 1, PC);
        // just inside the timeout the break still completes
        step(1, 8'hF0);
        idle(TO - 2);
        step(1, 8'h1C);
        step(0, 8'h00, 1, PC);
        // new event loads on the same edge as a code read
        step(1, 8'h1C);
        step(1, 8'h23, 1, PC);
        idle(2);
        step(0, 8'h00, 1, PC);
        // reset mid-sequence
        step(1, 8'hE0); step(1, 8'hF0);
        do_reset();
        step(1, 8'h74);
        idle(2);

        // random traffic
        for (int i = 0; i < 500; i++) begin
            logic [7:0] b;
            int gap;
            if ($urandom_range(0, 7) == 0)
                b = 8'($urandom);
            else
                b = pool[$urandom_range(0, 9)];
            step(1, b, 1'($urandom_range(0, 3) == 0),
                 ports[$urandom_range(0, 2)]);
            gap = ($urandom_range(0, 9) == 0) ?
                  $urandom_range(TO - 2, TO + 1) : $urandom_range(0, 3);
            for (int g = 0; g < gap; g++)
                step(0, 8'h00, 1'($urandom_range(0, 2) == 0),
                     ports[$urandom_range(0, 2)]);
        end
        idle(4);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
